// File: rtl/pc_sequencer4.sv
// pc_sequencer4
// 4-bit program-counter sequencer placed in front of an external 4-bit
// incrementer in the fetch path. The PC register feeds the incrementer
// through inc_a. The returned inc_sum/inc_cout supply the next sequential
// PC. The current PC is offered to the fetch stage over a valid/ready
// handshake. The block also supports jump redirection, halt on address
// wrap and a saturating count of accepted fetches.
//
// Parameters
//   RESET_PC      PC loaded at reset and on start
//   HALT_ON_WRAP  1: carry-out of a sequential step enters HALT
//                 0: wrap to 4'h0 and keep running
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   begin sequencing from IDLE or HALT
//   jump_valid   in   redirect request, honoured only in RUN
//   jump_addr    in   redirect target
//   fetch_ready  in   fetch stage accepts fetch_pc this cycle
//   fetch_valid  out  fetch_pc is valid (RUN)
//   fetch_pc     out  current PC
//   inc_a        out  incrementer operand, always the PC register
//   inc_sum      in   incrementer sum (PC+1 mod 16), same cycle
//   inc_cout     in   incrementer carry-out
//   halted       out  high in HALT
//   wrapped      out  sticky carry-out seen on an accepted sequential step
//   fetch_count  out  accepted fetches, saturating at 8'hFF
module pc_sequencer4 #(
    parameter logic [3:0] RESET_PC     = 4'h0,
    parameter bit         HALT_ON_WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       jump_valid,
    input  logic [3:0] jump_addr,
    input  logic       fetch_ready,
    output logic       fetch_valid,
    output logic [3:0] fetch_pc,
    output logic [3:0] inc_a,
    input  logic [3:0] inc_sum,
    input  logic       inc_cout,
    output logic       halted,
    output logic       wrapped,
    output logic [7:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] pc, pc_nxt;
    logic       wrapped_q, wrapped_nxt;
    logic [7:0] count_q, count_nxt;
    logic       fire;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // fetch_valid is a pure state decode, so fire has no path from
    // fetch_ready back into the valid output.
    assign fire = (state == S_RUN) && fetch_ready;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        wrapped_nxt = wrapped_q;
        count_nxt   = count_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = RESET_PC;
                    count_nxt   = 8'd0;
                    wrapped_nxt = 1'b0;
                end
            end

            S_RUN: begin
                if (fire)
                    count_nxt = sat_inc8(count_q);

                // A jump wins over sequential advance; without fire it
                // cancels the pending fetch, with fire the current PC is
                // still counted. Carry-out is irrelevant on a jump.
                if (jump_valid) begin
                    pc_nxt = jump_addr;
                end else if (fire) begin
                    if (!inc_cout) begin
                        pc_nxt = inc_sum;
                    end else begin
                        wrapped_nxt = 1'b1;
                        if (HALT_ON_WRAP) begin
                            state_nxt = S_HALT;
                            pc_nxt    = inc_sum;
                        end else begin
                            pc_nxt    = 4'h0;
                        end
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    state_nxt   = S_RUN;
                    pc_nxt      = RESET_PC;
                    count_nxt   = 8'd0;
                    wrapped_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            wrapped_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            wrapped_q <= wrapped_nxt;
            count_q   <= count_nxt;
        end
    end

    assign fetch_valid = (state == S_RUN);
    assign halted      = (state == S_HALT);
    assign fetch_pc    = pc;
    assign inc_a       = pc;
    assign wrapped     = wrapped_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer4.sv
// Directed bench for pc_sequencer4. Two instances share the stimulus: u_dut
// halts on wrap, u_nw wraps and keeps running. Each has its own behavioural
// 4-bit incrementer. Inputs are driven and outputs sampled 1 ns after
// the rising edge.
module tb_pc_sequencer4;

    logic       clk = 1'b0;
    logic       rst_n, start, jump_valid, fetch_ready;
    logic [3:0] jump_addr;

    logic       h_valid, h_halted, h_wrapped, h_cout;
    logic [3:0] h_pc, h_inc_a, h_sum;
    logic [7:0] h_count;

    logic       n_valid, n_halted, n_wrapped, n_cout;
    logic [3:0] n_pc, n_inc_a, n_sum;
    logic [7:0] n_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign h_sum  = h_inc_a + 4'd1;
    assign h_cout = (h_inc_a == 4'hF);
    assign n_sum  = n_inc_a + 4'd1;
    assign n_cout = (n_inc_a == 4'hF);

    pc_sequencer4 #(.RESET_PC(4'h0), .HALT_ON_WRAP(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .fetch_ready(fetch_ready), .fetch_valid(h_valid), .fetch_pc(h_pc),
        .inc_a(h_inc_a), .inc_sum(h_sum), .inc_cout(h_cout),
        .halted(h_halted), .wrapped(h_wrapped), .fetch_count(h_count)
    );

    pc_sequencer4 #(.RESET_PC(4'h0), .HALT_ON_WRAP(1'b0)) u_nw (
        .clk(clk), .rst_n(rst_n), .start(start),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .fetch_ready(fetch_ready), .fetch_valid(n_valid), .fetch_pc(n_pc),
        .inc_a(n_inc_a), .inc_sum(n_sum), .inc_cout(n_cout),
        .halted(n_halted), .wrapped(n_wrapped), .fetch_count(n_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; jump_valid = 1'b0;
        jump_addr = 4'h0; fetch_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // reset state
        chk("rst_valid",   h_valid,   0);
        chk("rst_halted",  h_halted,  0);
        chk("rst_pc",      h_pc,      0);
        chk("rst_inc_a",   h_inc_a,   0);
        chk("rst_count",   h_count,   0);
        chk("rst_wrapped", h_wrapped, 0);

        // idle ignores fetch_ready
        fetch_ready = 1'b1;
        step();
        chk("idle_valid", h_valid, 0);

        // start latency: one cycle to RUN at RESET_PC
        fetch_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_valid", h_valid, 1);
        chk("start_pc",    h_pc,    0);

        // full sweep 0..F with fetch_ready high
        fetch_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("seq_pc_%0d", i), h_pc, i);
            chk($sformatf("seq_v_%0d", i), h_valid, 1);
            step();
        end
        chk("wrap_halted",  h_halted,  1);
        chk("wrap_wrapped", h_wrapped, 1);
        chk("wrap_valid",   h_valid,   0);
        chk("wrap_count",   h_count,   16);
        chk("wrap_pc",      h_pc,      0);
        chk("nw_pc0",       n_pc,      0);
        chk("nw_halted",    n_halted,  0);
        chk("nw_valid",     n_valid,   1);
        chk("nw_wrapped",   n_wrapped, 1);
        step();
        chk("nw_pc1",       n_pc,      1);
        chk("nw_count17",   n_count,   17);
        chk("halt_count",   h_count,   16);
        chk("halt_pc",      h_pc,      0);

        // jump ignored in HALT (taken by the running instance)
        fetch_ready = 1'b0;
        jump_valid = 1'b1; jump_addr = 4'h9;
        step();
        jump_valid = 1'b0;
        chk("halt_jmp_pc",   h_pc,     0);
        chk("halt_jmp_halt", h_halted, 1);
        chk("nw_jmp_pc",     n_pc,     9);

        // start from HALT restarts; start in RUN is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pc",      h_pc,      0);
        chk("restart_valid",   h_valid,   1);
        chk("restart_count",   h_count,   0);
        chk("restart_wrapped", h_wrapped, 0);
        chk("nw_start_ign_pc", n_pc,      9);
        chk("nw_start_ign_wr", n_wrapped, 1);

        // advance to pc=5, then 3 cycles of backpressure
        fetch_ready = 1'b1;
        repeat (5) step();
        chk("pre_bp_pc", h_pc, 5);
        chk("nw_pc_e",   n_pc, 4'hE);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_pc_%0d", i),    h_pc,    5);
            chk($sformatf("bp_v_%0d", i),     h_valid, 1);
            chk($sformatf("bp_cnt_%0d", i),   h_count, 5);
        end
        fetch_ready = 1'b1;
        step();
        chk("bp_rel_pc",  h_pc,    6);
        chk("bp_rel_cnt", h_count, 6);
        chk("nw_pc_f",    n_pc,    4'hF);
        step();
        chk("nw_pc_0",    n_pc,    0);
        chk("nw_run",     n_valid, 1);
        step();
        chk("nw_pc_1",    n_pc,    1);
        chk("seq_cnt8",   h_count, 8);

        // jump with fire low cancels the pending fetch
        fetch_ready = 1'b0;
        jump_valid = 1'b1; jump_addr = 4'h3;
        step();
        chk("jmp_to3_pc", h_pc, 3);
        jump_addr = 4'hA;
        step();
        chk("jlo_pc",  h_pc,    4'hA);
        chk("jlo_cnt", h_count, 8);

        // jump with fire high counts the current PC
        jump_addr = 4'h3;
        step();
        fetch_ready = 1'b1; jump_addr = 4'hA;
        step();
        chk("jhi_pc",  h_pc,    4'hA);
        chk("jhi_cnt", h_count, 9);

        // jump at pc=F with fire high: no halt, no wrap
        fetch_ready = 1'b0; jump_addr = 4'hF;
        step();
        chk("jf_pre_pc", h_pc, 4'hF);
        fetch_ready = 1'b1; jump_addr = 4'h2;
        step();
        jump_valid = 1'b0;
        chk("jf_pc",      h_pc,      2);
        chk("jf_halted",  h_halted,  0);
        chk("jf_wrapped", h_wrapped, 0);
        chk("jf_valid",   h_valid,   1);
        chk("jf_cnt",     h_count,   10);
        chk("jf_inc_a",   h_inc_a,   2);

        // 300 fires on the non-halting instance saturate the count
        repeat (300) step();
        chk("sat_count",   n_count,   8'hFF);
        chk("sat_valid",   n_valid,   1);
        chk("sat_wrapped", n_wrapped, 1);
        chk("sat_h_halt",  h_halted,  1);

        // reset mid-RUN at pc=7 overrides start/jump/fire
        fetch_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        jump_valid = 1'b1; jump_addr = 4'h7;
        step();
        chk("mid_pc7", h_pc, 7);
        rst_n = 1'b0; start = 1'b1; fetch_ready = 1'b1; jump_addr = 4'hC;
        step();
        rst_n = 1'b1; start = 1'b0; jump_valid = 1'b0; fetch_ready = 1'b0;
        chk("mrst_valid",   h_valid,   0);
        chk("mrst_halted",  h_halted,  0);
        chk("mrst_pc",      h_pc,      0);
        chk("mrst_count",   h_count,   0);
        chk("mrst_wrapped", h_wrapped, 0);
        chk("mrst_nw_cnt",  n_count,   0);
        chk("mrst_nw_wr",   n_wrapped, 0);
        step();
        chk("mrst_idle", h_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
